// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two cache miss ports, the arbiter and the RAM port.
//
// Signals
//   icache : iREN, iaddr (requests in); iwait, iload (responses out of the arbiter)
//   dcache : dREN, dWEN, daddr, dstore (requests in); dwait, dload (responses out)
//   RAM    : ramREN, ramWEN, ramaddr, ramstore (driven by the arbiter); ramload, ramstate
//            (returned by the RAM). ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
//
// Modports
//   slave  : the arbiter's view (serves cache requests, drives the RAM port).
//   master : the surrounding caches/RAM view (issues requests, answers the RAM port).
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between icache fills and dcache fills/writebacks.
//
// The dcache wins ties, but once it has completed DBURST accesses while the icache is waiting
// the grant moves to the icache (and after IBURST icache completions back again), so a
// two-word dcache block moves back-to-back without starving instruction fetch. RAM handshake
// status is turned into per-requester wait signals; all RAM-side outputs are combinational
// from the registered grant state and the live request inputs.
//
// Ports
//   CLK          : clock, rising edge
//   nRST         : asynchronous active-low reset
//   bus          : mem_arbiter_if.slave (icache, dcache and RAM handshakes)
//   istall_count : cycles the icache spent waiting with iREN high (0 unless stats built)
//   dstall_count : cycles the dcache spent waiting with dREN|dWEN high (0 unless stats built)
//
// Parameters
//   DBURST : max consecutive dcache completions while iREN is pending
//   IBURST : max consecutive icache completions while a dcache request is pending
//
// Build option
//   MEM_ARB_STATS_EN : when defined, builds the two 32-bit wrapping stall counters; otherwise
//                      both count outputs are tied to zero and no counter flops exist.
module mem_arbiter #(
  parameter int unsigned DBURST = 2,
  parameter int unsigned IBURST = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_arbiter_if.slave        bus,
  output logic [31:0]         istall_count,
  output logic [31:0]         dstall_count
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  state_t     arb_pick;
  logic [1:0] burst_q, burst_d;
  logic [2:0] burst_inc;
  logic [1:0] burst_sat;
  logic       dreq;
  logic       d_done;
  logic       i_done;
  logic       d_limit;
  logic       i_limit;

  assign dreq = bus.dREN | bus.dWEN;

  // The burst counter saturates instead of wrapping, so a long run with nobody else waiting
  // never makes the other side wait extra completions once it starts requesting.
  assign burst_inc = {1'b0, burst_q} + 3'd1;
  assign burst_sat = (burst_q == 2'd3) ? 2'd3 : burst_inc[1:0];
  assign d_limit   = 32'(burst_inc) >= DBURST;
  assign i_limit   = 32'(burst_inc) >= IBURST;

  // Fresh arbitration from the current inputs; dcache wins a tie.
  always_comb begin
    if (dreq) begin
      arb_pick = DGRANT;
    end else if (bus.iREN) begin
      arb_pick = IGRANT;
    end else begin
      arb_pick = IDLE;
    end
  end

  // RAM port and wait outputs. Address/data pass straight through from the granted requester
  // so a multi-word block can change address between words without a bubble.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    d_done       = 1'b0;
    i_done       = 1'b0;
    unique case (state_q)
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        // A simultaneous read and write request is treated as a write.
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        d_done       = dreq && (bus.ramstate == RAM_ACCESS);
        bus.dwait    = ~d_done;
      end
      IGRANT: begin
        bus.ramaddr  = bus.iaddr;
        bus.ramREN   = bus.iREN;
        i_done       = bus.iREN && (bus.ramstate == RAM_ACCESS);
        bus.iwait    = ~i_done;
      end
      default: begin
      end
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  // Next grant. BUSY/FREE/ERROR simply hold the current grant; ERROR is never retried.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        state_d = arb_pick;
        burst_d = 2'd0;
      end
      DGRANT: begin
        if (!dreq) begin
          // Granted side went quiet: re-arbitrate now so the other side loses no cycle.
          state_d = arb_pick;
          burst_d = 2'd0;
        end else if (d_done) begin
          if (d_limit && bus.iREN) begin
            state_d = IGRANT;
            burst_d = 2'd0;
          end else begin
            burst_d = burst_sat;
          end
        end
      end
      IGRANT: begin
        if (!bus.iREN) begin
          state_d = arb_pick;
          burst_d = 2'd0;
        end else if (i_done) begin
          if (i_limit && dreq) begin
            state_d = DGRANT;
            burst_d = 2'd0;
          end else begin
            burst_d = burst_sat;
          end
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      burst_q <= 2'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] istall_q;
  logic [31:0] dstall_q;

  // Count every cycle a requester is asking but not completing; wraps at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_q <= '0;
      dstall_q <= '0;
    end else begin
      if (bus.iREN && bus.iwait) begin
        istall_q <= istall_q + 32'd1;
      end
      if (dreq && bus.dwait) begin
        dstall_q <= dstall_q + 32'd1;
      end
    end
  end

  assign istall_count = istall_q;
  assign dstall_count = dstall_q;
`else
  assign istall_count = '0;
  assign dstall_count = '0;
`endif

endmodule
